// File: rtl/led_pkg.sv
// +----------------------------------------------------------------------+
// | led_pkg - mode and breathe-direction encodings for led_pattern_gen   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package led_pkg;

  localparam int MODE_W = 2;

  typedef logic [MODE_W-1:0] led_mode_t;

  localparam logic [MODE_W-1:0] LED_OFF     = 2'd0;
  localparam logic [MODE_W-1:0] LED_ON      = 2'd1;
  localparam logic [MODE_W-1:0] LED_BLINK   = 2'd2;
  localparam logic [MODE_W-1:0] LED_BREATHE = 2'd3;

  localparam logic [0:0] DIR_UP = 1'b0;
  localparam logic [0:0] DIR_DN = 1'b1;

endpackage

`default_nettype wire

// File: rtl/led_pattern_gen_if.sv
// +----------------------------------------------------------------------+
// | led_pattern_gen_if - one-cycle configuration write port              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface led_pattern_gen_if
  import led_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int PWM_W  = 8
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                cfg_we;
  logic [CH_W-1:0]     cfg_ch;
  logic [MODE_W-1:0]   cfg_mode;
  logic [CNT_W-1:0]    cfg_half;
  logic [PWM_W-1:0]    cfg_duty;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_mode,
    output cfg_half,
    output cfg_duty
  );

  modport slave (
    input cfg_we,
    input cfg_ch,
    input cfg_mode,
    input cfg_half,
    input cfg_duty
  );

endinterface

`default_nettype wire

// File: rtl/led_channel.sv
// +----------------------------------------------------------------------+
// | led_channel - per-LED config, blink/breathe state and output flop    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module led_channel
  import led_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int PWM_W    = 8,
  parameter int DEF_HALF = 500
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              i_tick,
  input  wire logic [PWM_W-1:0]  i_pwm_cnt,
  input  wire logic              i_wr,
  input  wire logic [MODE_W-1:0] i_mode,
  input  wire logic [CNT_W-1:0]  i_half,
  input  wire logic [PWM_W-1:0]  i_duty,
  output logic                   o_led
);

  localparam logic [CNT_W-1:0] c_DEF_HALF = CNT_W'(DEF_HALF);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [PWM_W-1:0] c_PWM_ONE  = PWM_W'(1);
  localparam logic [PWM_W-1:0] c_PWM_MAX  = '1;

  logic [MODE_W-1:0] r_mode;
  logic [CNT_W-1:0]  r_half;
  logic [PWM_W-1:0]  r_duty;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_phase;
  logic [PWM_W-1:0]  r_level;
  logic [0:0]        r_dir;
  logic              r_led;
  logic              w_led_nxt;

  // All-ones duty forces the output on even though pwm_cnt never exceeds it.
  function automatic logic pwm_on(input logic [PWM_W-1:0] d, input logic [PWM_W-1:0] cnt);
    return (d == c_PWM_MAX) || (cnt < d);
  endfunction

  always_comb begin
    w_led_nxt = 1'b0;
    case (r_mode)
      LED_ON:      w_led_nxt = pwm_on(r_duty, i_pwm_cnt);
      LED_BLINK:   w_led_nxt = r_phase & pwm_on(r_duty, i_pwm_cnt);
      LED_BREATHE: w_led_nxt = pwm_on(r_level, i_pwm_cnt);
      default:     w_led_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode  <= LED_OFF;
      r_half  <= c_DEF_HALF;
      r_duty  <= c_PWM_MAX;
      r_cnt   <= '0;
      r_phase <= 1'b1;
      r_level <= '0;
      r_dir   <= DIR_UP;
      r_led   <= 1'b0;
    end else begin
      r_led <= w_led_nxt;
      if (i_wr) begin
        r_mode  <= i_mode;
        r_half  <= (i_half == '0) ? c_CNT_ONE : i_half;
        r_duty  <= i_duty;
        r_cnt   <= '0;
        r_phase <= 1'b1;
        r_level <= '0;
        r_dir   <= DIR_UP;
      end else if (i_tick) begin
        if (r_mode == LED_BLINK) begin
          if (r_cnt == r_half - c_CNT_ONE) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        if (r_mode == LED_BREATHE) begin
          // Direction flips on the step that lands on the end value.
          case (r_dir)
            DIR_UP: begin
              r_level <= r_level + c_PWM_ONE;
              if (r_level == c_PWM_MAX - c_PWM_ONE) r_dir <= DIR_DN;
            end
            default: begin
              r_level <= r_level - c_PWM_ONE;
              if (r_level == c_PWM_ONE) r_dir <= DIR_UP;
            end
          endcase
        end
      end
    end
  end

  assign o_led = r_led;

endmodule

`default_nettype wire

// File: rtl/led_pattern_gen.sv
// +----------------------------------------------------------------------+
// | led_pattern_gen - multi-channel OFF/ON/BLINK/BREATHE LED driver      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module led_pattern_gen
  import led_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int TICK_DIV = 10,
  parameter int CNT_W    = 16,
  parameter int PWM_W    = 8,
  parameter int DEF_HALF = 500
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  led_pattern_gen_if.slave   cfg,
  output logic               o_tick,
  output logic [NUM_CH-1:0]  o_led
);

  localparam int c_PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);
  localparam logic [c_PRE_W-1:0] c_PRE_ONE  = c_PRE_W'(1);
  localparam logic [PWM_W-1:0]   c_PWM_ONE  = PWM_W'(1);

  logic [c_PRE_W-1:0] r_pre;
  logic [PWM_W-1:0]   r_pwm_cnt;
  logic               w_tick;
  logic [NUM_CH-1:0]  w_wr;

  assign w_tick = (r_pre == c_PRE_LAST);
  assign o_tick = w_tick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre     <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_pre     <= w_tick ? '0 : r_pre + c_PRE_ONE;
      r_pwm_cnt <= r_pwm_cnt + c_PWM_ONE;
    end
  end

  // An out-of-range cfg_ch matches no channel, so the write is dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_wr[i] = cfg.cfg_we && (cfg.cfg_ch == c_CH_W'(i));

    led_channel #(
      .CNT_W    (CNT_W),
      .PWM_W    (PWM_W),
      .DEF_HALF (DEF_HALF)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_tick    (w_tick),
      .i_pwm_cnt (r_pwm_cnt),
      .i_wr      (w_wr[i]),
      .i_mode    (cfg.cfg_mode),
      .i_half    (cfg.cfg_half),
      .i_duty    (cfg.cfg_duty),
      .o_led     (o_led[i])
    );
  end

endmodule

`default_nettype wire
